load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Consumes the control unit's memory-op fields (lsu_we, data_width, lsu_sign_extend) and executes
//  loads/stores over a valid/ack data-memory bus. Aligns and steers byte lanes on stores, and extracts
//  and sign/zero-extends on loads. Stalls the core while a transfer is outstanding and reports faults.
//  Sits between the execute stage (address = ALU result, store data = rs2) and data memory.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT without mem_ack before timeout fault (1..65535)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  start            in   1   pulse: begin op using the fields below (sampled only in IDLE)
//  lsu_we           in   1   1=store, 0=load
//  data_width       in   2   `DATAWIDTH_BYTE=00, `DATAWIDTH_SHORT=01, `DATAWIDTH_WORD=10, 11 illegal
//  lsu_sign_extend  in   1   loads only: 1=sign-extend, 0=zero-extend
//  addr             in   32  byte address (ALU result)
//  wdata            in   32  store data (rs2); low byte/half used for SB/SH
//  busy             out  1   high from cycle after accepted start until done cycle inclusive
//  done             out  1   one-cycle completion pulse
//  rdata            out  32  extended load result; valid when done && !lsu_we; holds until next done
//  fault            out  2   valid with done: 00 none, 01 misaligned, 10 illegal width, 11 timeout
//  mem_req          out  1   bus request; held with addr/we/be/wdata stable until mem_ack
//  mem_we           out  1   bus write enable
//  mem_addr         out  32  word address {addr[31:2],2'b00}
//  mem_be           out  4   byte enables
//  mem_wdata        out  32  lane-replicated store data
//  mem_ack          in   1   sampled only while mem_req=1; completes transfer that cycle
//  mem_rdata        in   32  load word; valid in the mem_ack cycle
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, mem_req, mem_we=0; mem_be=0; mem_addr, mem_wdata, rdata=0; fault=00.
//  FSM (registered outputs):
//   IDLE : start && legal && aligned -> WAIT, drive mem_* next cycle. start && !legal/aligned -> RESP
//          with fault. No start -> stay in IDLE.
//   WAIT : mem_req=1. mem_ack -> capture/extend mem_rdata (loads) -> RESP. Counter reaches
//          TIMEOUT_CYCLES -> RESP with fault=11, mem_req drops.
//   RESP : done=1 for exactly one cycle -> IDLE. start in RESP is ignored.
//  Latency: start@T -> mem_req@T+1. ack@T+k (k>=1) -> done@T+k+1. Minimum is 2 cycles. Faults raise done@T+1.
//  Alignment: SH needs addr[0]=0; SW needs addr[1:0]=00; byte is always aligned. Illegal width wins over
//   misalignment. A faulting op issues no mem_req and leaves rdata unchanged.
//  Store lanes: BYTE be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SHORT be=addr[1]?1100:0011,
//   wdata={2{wdata[15:0]}}; WORD be=1111, wdata as given. Loads drive the same be and mem_we=0.
//  Load extract: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16]; extend per
//   lsu_sign_extend (latched at start). Word loads ignore sign_extend.
//  Timeout counter: cleared on entry to WAIT; width $clog2(TIMEOUT_CYCLES+1). An ack arriving in the
//   same cycle the counter hits TIMEOUT_CYCLES wins, so the op completes with no fault.
//  start while busy is ignored; the op fields are latched at acceptance and later changes have no effect.
//  mem_ack with mem_req=0 is ignored.
//  rst mid-transaction: IDLE next cycle, mem_req=0, no done pulse.
// STRUCTURE
//  `DATAWIDTH_* stay in defines.vh. New lsu_pkg holds typedef enum {IDLE,WAIT,RESP} lsu_state_t and
//   the LSU_FAULT_* 2-bit codes.
//  One combinational sub-module, lsu_lane_align: (addr[1:0], width, sign_ext, wdata, mem_rdata) ->
//   (be, aligned wdata, extended rdata, misaligned, illegal). The top holds the FSM, latches and timeout.
// TESTING
//  SB addr=0x1003 wdata=0x000000A5 -> mem_addr=0x1000, be=1000, mem_wdata=0xA5A5A5A5, done 1 cycle after ack.
//  LB addr=0x2001 sign_ext=1, mem_rdata=0x0000_80_00 -> rdata=0xFFFFFF80; same op as LBU -> 0x00000080.
//  LH addr=0x2002 mem_rdata=0x8001_1234 sign_ext=1 -> rdata=0xFFFF8001. LW addr=0x2002 -> fault=01,
//   no mem_req, done@T+1.
//  LW with ack held low for TIMEOUT_CYCLES=4 -> fault=11 and mem_req falls. Ack on cycle 4 -> fault=00.
//  start pulses while busy plus a spurious mem_ack in IDLE -> exactly one transaction, one done.
//  rst asserted in WAIT -> mem_req=0 and busy=0 next cycle, no done. Next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and codes for the load/store unit
//
// Purpose: FSM state type, memory access width codes and fault codes used by
//          load_store_unit and lsu_lane_align.
// Ports:   none (package)

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Access width encoding as produced by the control unit.
  localparam logic [1:0] DATAWIDTH_BYTE  = 2'b00;
  localparam logic [1:0] DATAWIDTH_SHORT = 2'b01;
  localparam logic [1:0] DATAWIDTH_WORD  = 2'b10;

  // Fault codes reported alongside done.
  localparam logic [1:0] LSU_FAULT_NONE      = 2'b00;
  localparam logic [1:0] LSU_FAULT_MISALIGN  = 2'b01;
  localparam logic [1:0] LSU_FAULT_ILLEGAL   = 2'b10;
  localparam logic [1:0] LSU_FAULT_TIMEOUT   = 2'b11;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering and load extraction for the LSU
//
// Purpose: purely combinational. Computes byte enables and lane-replicated
//          store data from the low address bits and width, extracts and
//          extends the addressed bytes of a loaded word, and flags illegal
//          widths and misaligned accesses.
// Ports:
//   addr_lo     in   2   addr[1:0] of the access
//   width       in   2   access width code
//   sign_ext    in   1   1 = sign-extend sub-word loads, 0 = zero-extend
//   wdata       in   32  raw store data
//   mem_rdata   in   32  word returned by memory
//   be          out  4   byte enables (0 for an illegal width)
//   wdata_al    out  32  lane-replicated store data
//   rdata_ext   out  32  extracted and extended load data
//   misaligned  out  1   access crosses its natural alignment
//   illegal     out  1   width code is not a legal encoding

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    wdata_al   = wdata;
    rdata_ext  = mem_rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (width)
      DATAWIDTH_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_al  = {4{wdata[7:0]}};
        rdata_ext = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      DATAWIDTH_SHORT: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_al   = {2{wdata[15:0]}};
        rdata_ext  = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        misaligned = addr_lo[0];
      end
      DATAWIDTH_WORD: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        // Illegal width takes priority, so misaligned stays low here.
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between execute stage and data memory
//
// Purpose: accepts a memory op on start, issues it on a req/ack bus with
//          steered byte lanes, extends load data, and reports completion
//          with a one-cycle done pulse and a fault code.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            begin an op (sampled only in IDLE)
//   lsu_we           1 = store, 0 = load
//   data_width       00 byte, 01 half, 10 word, 11 illegal
//   lsu_sign_extend  sign- vs zero-extension for sub-word loads
//   addr, wdata      byte address and store data
//   busy, done       op in flight / completion pulse
//   rdata, fault     extended load result / fault code valid with done
//   mem_req .. mem_wdata  registered bus request, held until mem_ack
//   mem_ack, mem_rdata    bus completion and load word

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        lsu_we,
  input  logic [1:0]  data_width,
  input  logic        lsu_sign_extend,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state;
  logic        lat_we;
  logic        lat_sext;
  logic [1:0]  lat_width;
  logic [1:0]  lat_addr_lo;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_nxt;
  logic        timeout_hit;

  logic        in_idle;
  logic [1:0]  al_addr_lo;
  logic [1:0]  al_width;
  logic        al_sext;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misaligned;
  logic        al_illegal;

  // In IDLE the aligner looks at the live op fields so the request can be
  // built on the accepting edge; afterwards it uses the latched copies so
  // later changes on the inputs cannot disturb the in-flight op.
  assign in_idle    = (state == IDLE);
  assign al_addr_lo = in_idle ? addr[1:0]       : lat_addr_lo;
  assign al_width   = in_idle ? data_width      : lat_width;
  assign al_sext    = in_idle ? lsu_sign_extend : lat_sext;

  lsu_lane_align u_lane_align (
    .addr_lo    (al_addr_lo),
    .width      (al_width),
    .sign_ext   (al_sext),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .be         (al_be),
    .wdata_al   (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  // wait_cnt holds the number of WAIT cycles already elapsed without ack;
  // the op times out at the end of the TIMEOUT_CYCLES-th WAIT cycle.
  assign cnt_nxt     = wait_cnt + CW'(1);
  assign timeout_hit = (cnt_nxt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= 32'h0;
      fault       <= LSU_FAULT_NONE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_be      <= 4'b0000;
      mem_wdata   <= 32'h0;
      lat_we      <= 1'b0;
      lat_sext    <= 1'b0;
      lat_width   <= 2'b00;
      lat_addr_lo <= 2'b00;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lat_we      <= lsu_we;
            lat_sext    <= lsu_sign_extend;
            lat_width   <= data_width;
            lat_addr_lo <= addr[1:0];
            busy        <= 1'b1;
            if (al_illegal) begin
              fault <= LSU_FAULT_ILLEGAL;
              done  <= 1'b1;
              state <= RESP;
            end else if (al_misaligned) begin
              fault <= LSU_FAULT_MISALIGN;
              done  <= 1'b1;
              state <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= lsu_we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
              wait_cnt  <= '0;
              state     <= WAIT;
            end
          end
        end

        WAIT: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (mem_ack && mem_req) begin
            if (!lat_we) begin
              rdata <= al_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            fault   <= LSU_FAULT_NONE;
            done    <= 1'b1;
            state   <= RESP;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            fault   <= LSU_FAULT_TIMEOUT;
            done    <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= cnt_nxt;
          end
        end

        RESP: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        lsu_we;
  logic [1:0]  data_width;
  logic        lsu_sign_extend;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  // Bus values seen in the first request cycle of the last transaction.
  logic        seen_we;
  logic [31:0] seen_addr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  int          req_cycles;
  int          done_cnt;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .lsu_we          (lsu_we),
    .data_width      (data_width),
    .lsu_sign_extend (lsu_sign_extend),
    .addr            (addr),
    .wdata           (wdata),
    .busy            (busy),
    .done            (done),
    .rdata           (rdata),
    .fault           (fault),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Issues one op, acks it in request cycle ack_cycle
  // (0 = never), returns the cycle index (relative to start) of done, or -1.
  task automatic txn(input logic we, input logic [1:0] w, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] mrd, input int ack_cycle,
                     output int done_lat);
    done_lat   = -1;
    req_cycles = 0;
    seen_we    = 1'bx;
    seen_addr  = 32'hx;
    seen_be    = 4'hx;
    seen_wdata = 32'hx;
    lsu_we = we; data_width = w; lsu_sign_extend = sx; addr = a; wdata = wd;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        done_lat = c;
        break;
      end
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          seen_we = mem_we; seen_addr = mem_addr; seen_be = mem_be; seen_wdata = mem_wdata;
        end
      end
      if (mem_req && c == ack_cycle) begin
        mem_ack = 1'b1; mem_rdata = mrd;
      end else begin
        mem_ack = 1'b0; mem_rdata = 32'h5555_5555;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h5555_5555;
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; lsu_we = 1'b0; data_width = 2'b00; lsu_sign_extend = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    {31'h0, busy},    32'h0);
    check("rst_done",    {31'h0, done},    32'h0);
    check("rst_req",     {31'h0, mem_req}, 32'h0);
    check("rst_we",      {31'h0, mem_we},  32'h0);
    check("rst_be",      {28'h0, mem_be},  32'h0);
    check("rst_addr",    mem_addr,         32'h0);
    check("rst_wdata",   mem_wdata,        32'h0);
    check("rst_rdata",   rdata,            32'h0);
    check("rst_fault",   {30'h0, fault},   32'h0);
    rst = 1'b0;
    @(negedge clk);

    // SB 0x1003
    txn(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, lat);
    check("sb_lat",   lat,                  32'd2);
    check("sb_addr",  seen_addr,            32'h0000_1000);
    check("sb_be",    {28'h0, seen_be},     32'h8);
    check("sb_wdata", seen_wdata,           32'hA5A5_A5A5);
    check("sb_we",    {31'h0, seen_we},     32'h1);
    check("sb_fault", {30'h0, fault},       32'h0);
    check("sb_busy_at_done", {31'h0, busy}, 32'h1);
    check("sb_req_at_done", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    check("sb_done_one_cycle", {31'h0, done}, 32'h0);
    check("sb_busy_after",     {31'h0, busy}, 32'h0);

    // LB / LBU 0x2001
    txn(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 32'h0000_8000, 2, lat);
    check("lb_lat",   lat,               32'd3);
    check("lb_be",    {28'h0, seen_be},  32'h2);
    check("lb_we",    {31'h0, seen_we},  32'h0);
    check("lb_rdata", rdata,             32'hFFFF_FF80);
    @(negedge clk);
    txn(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 32'h0000_8000, 1, lat);
    check("lbu_rdata", rdata, 32'h0000_0080);
    @(negedge clk);

    // LH 0x2002 sign-extended
    txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, lat);
    check("lh_be",    {28'h0, seen_be}, 32'hC);
    check("lh_addr",  seen_addr,        32'h0000_2000);
    check("lh_rdata", rdata,            32'hFFFF_8001);
    @(negedge clk);

    // LW misaligned: fault, no request, rdata kept
    txn(1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0, 32'h1111_1111, 1, lat);
    check("lw_mis_lat",   lat,            32'd1);
    check("lw_mis_fault", {30'h0, fault}, 32'h1);
    check("lw_mis_req",   req_cycles,     32'd0);
    check("lw_mis_rdata", rdata,          32'hFFFF_8001);
    @(negedge clk);

    // Illegal width on a misaligned address: illegal wins
    txn(1'b0, 2'b11, 1'b0, 32'h0000_2001, 32'h0, 32'h1111_1111, 1, lat);
    check("ill_lat",   lat,            32'd1);
    check("ill_fault", {30'h0, fault}, 32'h2);
    check("ill_req",   req_cycles,     32'd0);
    @(negedge clk);

    // SH upper half, then SH misaligned
    txn(1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'h1234_BEEF, 32'h0, 1, lat);
    check("sh_be",    {28'h0, seen_be}, 32'hC);
    check("sh_wdata", seen_wdata,       32'hBEEF_BEEF);
    check("sh_fault", {30'h0, fault},   32'h0);
    @(negedge clk);
    txn(1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'h1234_BEEF, 32'h0, 1, lat);
    check("sh_mis_fault", {30'h0, fault}, 32'h1);
    @(negedge clk);

    // Timeout with ack never arriving
    txn(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, lat);
    check("to_lat",   lat,             32'd5);
    check("to_reqs",  req_cycles,      32'd4);
    check("to_fault", {30'h0, fault},  32'h3);
    check("to_req",   {31'h0, mem_req}, 32'h0);
    check("to_rdata", rdata,           32'hFFFF_8001);
    @(negedge clk);

    // Ack on the last allowed cycle wins over timeout
    txn(1'b0, 2'b10, 1'b1, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 4, lat);
    check("ack4_lat",   lat,            32'd5);
    check("ack4_fault", {30'h0, fault}, 32'h0);
    check("ack4_rdata", rdata,          32'hDEAD_BEEF);
    @(negedge clk);

    // Spurious ack in IDLE, restarts while busy, start during RESP
    mem_ack = 1'b1;
    @(negedge clk);
    check("spur_req",  {31'h0, mem_req}, 32'h0);
    check("spur_done", {31'h0, done},    32'h0);
    mem_ack = 1'b0;
    done_cnt = 0;
    req_cycles = 0;
    lsu_we = 1'b0; data_width = 2'b10; lsu_sign_extend = 1'b0; addr = 32'h0000_5000; wdata = 32'h0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lsu_we = 1'b1; addr = 32'h0000_6000;
    for (int c = 1; c <= 12; c++) begin
      if (done) done_cnt++;
      if (mem_req) req_cycles++;
      if (c == 3) begin
        check("busy_addr", mem_addr,          32'h0000_5000);
        check("busy_we",   {31'h0, mem_we},   32'h0);
      end
      start   = (c == 1 || c == 2 || c == 4);
      mem_ack = (c == 3);
      mem_rdata = (c == 3) ? 32'hCAFE_F00D : 32'h5555_5555;
      @(negedge clk);
    end
    start = 1'b0;
    mem_ack = 1'b0;
    check("busy_done_cnt", done_cnt,   32'd1);
    check("busy_req_cnt",  req_cycles, 32'd3);
    check("busy_rdata",    rdata,      32'hCAFE_F00D);

    // Reset in WAIT
    lsu_we = 1'b0; data_width = 2'b10; addr = 32'h0000_7000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstw_req_before", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_req",  {31'h0, mem_req}, 32'h0);
    check("rstw_busy", {31'h0, busy},    32'h0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("rstw_no_done", done_cnt, 32'd0);
    txn(1'b0, 2'b10, 1'b0, 32'h0000_7004, 32'h0, 32'h0102_0304, 1, lat);
    check("post_rst_lat",   lat,            32'd2);
    check("post_rst_fault", {30'h0, fault}, 32'h0);
    check("post_rst_rdata", rdata,          32'h0102_0304);
    check("post_rst_addr",  seen_addr,      32'h0000_7004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
